// File: rtl/input_debounce_sync.sv
// input_debounce_sync: per-bit synchroniser followed by a counter-based bounce filter.
// Define DEBOUNCE_EDGE_EN to build the registered rise/fall pulse outputs; otherwise they read 0.
module input_debounce_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int THRESH      = 4,
  parameter int PRESCALE    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW = (THRESH > 1) ? $clog2(THRESH) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(THRESH - 1);

  generate
    if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4) || (THRESH < 1) || (THRESH > 255) ||
        (PRESCALE < 1) || (PRESCALE > 65535) || (WIDTH < 1)) begin : g_bad_param
      $error("input_debounce_sync: parameter out of legal range");
    end
  endgenerate

  logic [WIDTH-1:0]          r_sync [SYNC_STAGES];
  logic [WIDTH-1:0]          w_s;
  logic [PW-1:0]             r_pre;
  logic [PW-1:0]             w_pre_nxt;
  logic                      w_tick;
  logic [WIDTH-1:0][CW-1:0]  r_cnt;
  logic [WIDTH-1:0][CW-1:0]  w_cnt_nxt;
  logic [WIDTH-1:0]          r_dout;
  logic [WIDTH-1:0]          w_upd;
  logic [WIDTH-1:0]          w_dout_nxt;

  // Synchroniser chain runs regardless of ena so the filter always sees fresh samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= '0;
      end
    end else begin
      r_sync[0] <= din;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Free-running tick prescaler; wraps in the same cycle the tick fires.
  always_comb begin
    w_pre_nxt = r_pre;
    if (ena) begin
      if (r_pre == PRE_LAST) begin
        w_pre_nxt = '0;
      end else begin
        w_pre_nxt = r_pre + PW'(1);
      end
    end else begin
      w_pre_nxt = r_pre;
    end
  end

  assign w_tick = ena && (r_pre == PRE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
    end else begin
      r_pre <= w_pre_nxt;
    end
  end

  // Per-channel stability counters; agreement with dout discards any partial count.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_upd     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_s[i] == r_dout[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (w_tick && (r_cnt[i] == CNT_LAST)) begin
        w_cnt_nxt[i] = '0;
        w_upd[i]     = 1'b1;
      end else if (w_tick) begin
        w_cnt_nxt[i] = r_cnt[i] + CW'(1);
      end else begin
        w_cnt_nxt[i] = r_cnt[i];
      end
    end
  end

  assign w_dout_nxt = (r_dout & ~w_upd) | (w_s & w_upd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_dout <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_dout <= w_dout_nxt;
    end
  end

  assign dout = r_dout;

`ifdef DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;

  // Pulses land in the same cycle dout first shows its new value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= w_upd & w_s;
      r_fall <= w_upd & ~w_s;
    end
  end

  assign rise = r_rise;
  assign fall = r_fall;
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule

// File: tb/tb_input_debounce_sync.sv
// Directed self-checking bench for input_debounce_sync (default instance plus a
// PRESCALE=3/THRESH=2 instance). Edge expectations follow the DEBOUNCE_EDGE_EN build.
module tb_input_debounce_sync;

`ifdef DEBOUNCE_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] din;
  logic [7:0] dout;
  logic [7:0] rise;
  logic [7:0] fall;
  logic [7:0] din_p;
  logic [7:0] dout_p;
  logic [7:0] rise_p;
  logic [7:0] fall_p;

  int pass_cnt;
  int total_cnt;

  input_debounce_sync #(
    .WIDTH(8), .SYNC_STAGES(2), .THRESH(4), .PRESCALE(1)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .din(din),
    .dout(dout), .rise(rise), .fall(fall)
  );

  input_debounce_sync #(
    .WIDTH(8), .SYNC_STAGES(2), .THRESH(2), .PRESCALE(3)
  ) dut_p (
    .clk(clk), .rst(rst), .ena(ena), .din(din_p),
    .dout(dout_p), .rise(rise_p), .fall(fall_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [7:0] exp_e;
    tick(2);
    total_cnt++;
    if (dout !== 8'h00) $display("FAIL reset_dout: got %h want %h", dout, 8'h00); else pass_cnt++;
    total_cnt++;
    if (rise !== 8'h00) $display("FAIL reset_rise: got %h want %h", rise, 8'h00); else pass_cnt++;
    total_cnt++;
    if (fall !== 8'h00) $display("FAIL reset_fall: got %h want %h", fall, 8'h00); else pass_cnt++;
    rst = 1'b0;
    din = 8'hFF;
    tick(5);
    total_cnt++;
    if (dout !== 8'h00) $display("FAIL reset_early: got %h want %h", dout, 8'h00); else pass_cnt++;
    tick(1);
    exp_e = EDGE ? 8'hFF : 8'h00;
    total_cnt++;
    if (dout !== 8'hFF) $display("FAIL first_dout: got %h want %h", dout, 8'hFF); else pass_cnt++;
    total_cnt++;
    if (rise !== exp_e) $display("FAIL first_rise: got %h want %h", rise, exp_e); else pass_cnt++;
    // asynchronous reset between edges while dout and rise are set
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (dout !== 8'h00) $display("FAIL async_rst_dout: got %h want %h", dout, 8'h00); else pass_cnt++;
    total_cnt++;
    if (rise !== 8'h00) $display("FAIL async_rst_rise: got %h want %h", rise, 8'h00); else pass_cnt++;
    tick(1);
    rst = 1'b0;
    tick(5);
    total_cnt++;
    if (dout !== 8'h00) $display("FAIL post_rst_early: got %h want %h", dout, 8'h00); else pass_cnt++;
    tick(1);
    total_cnt++;
    if (dout !== 8'hFF) $display("FAIL post_rst_dout: got %h want %h", dout, 8'hFF); else pass_cnt++;
    din = 8'h00;
    tick(6);
    total_cnt++;
    if (dout !== 8'h00) $display("FAIL all_fall_dout: got %h want %h", dout, 8'h00); else pass_cnt++;
    total_cnt++;
    if (fall !== exp_e) $display("FAIL all_fall_pulse: got %h want %h", fall, exp_e); else pass_cnt++;
    tick(1);
    total_cnt++;
    if (fall !== 8'h00) $display("FAIL all_fall_clear: got %h want %h", fall, 8'h00); else pass_cnt++;
  endtask

  task automatic test_clean_step();
    logic [7:0] exp_d;
    logic [7:0] exp_r;
    din[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      exp_d = (k >= 6) ? 8'h01 : 8'h00;
      exp_r = (EDGE && (k == 6)) ? 8'h01 : 8'h00;
      total_cnt++;
      if (dout !== exp_d) $display("FAIL step_dout k=%0d: got %h want %h", k, dout, exp_d); else pass_cnt++;
      total_cnt++;
      if (rise !== exp_r) $display("FAIL step_rise k=%0d: got %h want %h", k, rise, exp_r); else pass_cnt++;
      total_cnt++;
      if (fall !== 8'h00) $display("FAIL step_fall k=%0d: got %h want %h", k, fall, 8'h00); else pass_cnt++;
    end
    din[0] = 1'b0;
    tick(6);
    exp_r = EDGE ? 8'h01 : 8'h00;
    total_cnt++;
    if (fall !== exp_r) $display("FAIL step_fall_pulse: got %h want %h", fall, exp_r); else pass_cnt++;
    total_cnt++;
    if (dout !== 8'h00) $display("FAIL step_back_low: got %h want %h", dout, 8'h00); else pass_cnt++;
    tick(1);
  endtask

  task automatic test_bounce();
    logic [7:0] pattern;
    logic [7:0] exp_r;
    pattern = 8'b0111_0111;
    for (int k = 0; k < 8; k++) begin
      din[3] = pattern[k];
      tick(1);
      total_cnt++;
      if (dout !== 8'h00) $display("FAIL bounce_hold k=%0d: got %h want %h", k, dout, 8'h00); else pass_cnt++;
    end
    din[3] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      total_cnt++;
      if (dout[3] !== (k == 6)) $display("FAIL bounce_settle k=%0d: got %b want %b", k, dout[3], (k == 6)); else pass_cnt++;
    end
    exp_r = EDGE ? 8'h08 : 8'h00;
    total_cnt++;
    if (rise !== exp_r) $display("FAIL bounce_rise: got %h want %h", rise, exp_r); else pass_cnt++;
    din[3] = 1'b0;
    tick(7);
    total_cnt++;
    if (dout !== 8'h00) $display("FAIL bounce_cleanup: got %h want %h", dout, 8'h00); else pass_cnt++;
  endtask

  task automatic test_ena_freeze();
    logic [7:0] exp_r;
    din[5] = 1'b1;
    tick(4);
    ena = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      total_cnt++;
      if (dout !== 8'h00 || rise !== 8'h00) $display("FAIL freeze_hold k=%0d: got dout=%h rise=%h want 00/00", k, dout, rise); else pass_cnt++;
    end
    ena = 1'b1;
    tick(1);
    total_cnt++;
    if (dout !== 8'h00) $display("FAIL freeze_resume1: got %h want %h", dout, 8'h00); else pass_cnt++;
    tick(1);
    exp_r = EDGE ? 8'h20 : 8'h00;
    total_cnt++;
    if (dout !== 8'h20) $display("FAIL freeze_resume2: got %h want %h", dout, 8'h20); else pass_cnt++;
    total_cnt++;
    if (rise !== exp_r) $display("FAIL freeze_rise: got %h want %h", rise, exp_r); else pass_cnt++;
    din[5] = 1'b0;
    tick(7);
    total_cnt++;
    if (dout !== 8'h00) $display("FAIL freeze_cleanup: got %h want %h", dout, 8'h00); else pass_cnt++;
  endtask

  task automatic test_prescale();
    int seen;
    seen = 0;
    din_p[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if ((seen == 0) && (dout_p[1] === 1'b1)) seen = k;
    end
    total_cnt++;
    if ((seen < 6) || (seen > 8)) $display("FAIL prescale_window: got edge %0d want 6..8", seen); else pass_cnt++;
    total_cnt++;
    if (dout_p !== 8'h02) $display("FAIL prescale_dout: got %h want %h", dout_p, 8'h02); else pass_cnt++;
    total_cnt++;
    if (rise_p !== 8'h00 || fall_p !== 8'h00) $display("FAIL prescale_pulse_clear: got %h/%h want 00/00", rise_p, fall_p); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_r;
    din = 8'hA5;
    tick(5);
    total_cnt++;
    if (dout !== 8'h00) $display("FAIL multi_early: got %h want %h", dout, 8'h00); else pass_cnt++;
    tick(1);
    exp_r = EDGE ? 8'hA5 : 8'h00;
    total_cnt++;
    if (dout !== 8'hA5) $display("FAIL multi_dout: got %h want %h", dout, 8'hA5); else pass_cnt++;
    total_cnt++;
    if (rise !== exp_r) $display("FAIL multi_rise: got %h want %h", rise, exp_r); else pass_cnt++;
    din = 8'h5A;
    tick(6);
    total_cnt++;
    if (dout !== 8'h5A) $display("FAIL swap_dout: got %h want %h", dout, 8'h5A); else pass_cnt++;
    exp_r = EDGE ? 8'h5A : 8'h00;
    total_cnt++;
    if (rise !== exp_r) $display("FAIL swap_rise: got %h want %h", rise, exp_r); else pass_cnt++;
    exp_r = EDGE ? 8'hA5 : 8'h00;
    total_cnt++;
    if (fall !== exp_r) $display("FAIL swap_fall: got %h want %h", fall, exp_r); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst   = 1'b1;
    ena   = 1'b1;
    din   = 8'h00;
    din_p = 8'h00;
    test_reset();
    test_clean_step();
    test_bounce();
    test_ena_freeze();
    test_prescale();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
